mat_result_serializer: RTL
==========================

# mat_result_serializer

Output-side companion to the 3x3 matrix multiplier. Accepts the packed 72-bit result matrix on its one-cycle valid pulse and streams it out as nine 8-bit elements, row-major, over a valid/ready byte interface. Two result matrices can be held at once, so back-to-back multiplier results are not lost while the downstream consumer applies backpressure.

## Interface
- ELEM_W, 8: element width in bits.
- DIM, 3: matrix dimension; NUM_ELEMS = DIM*DIM = 9.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-cycle pulse qualifying in_matrix; driven from the multiplier's valid_out.
- in_matrix  in  NUM_ELEMS*ELEM_W (72)  packed matrix; element k at bits [k*8 +: 8]; k = row*3+col.
- in_ready  out  1  high when a buffer slot is free.
- m_valid  out  1  output byte valid.
- m_data  out  ELEM_W  output byte.
- m_index  out  4  element index 0..8 of m_data; 4'hF for the header byte.
- m_last  out  1  high with element 8.
- m_ready  in  1  consumer accepts the byte when m_valid && m_ready.
- busy  out  1  buffer non-empty or frame in progress.
- overflow  out  1  sticky; set when in_valid arrives while in_ready is low.
- clr_overflow  in  1  synchronous clear of overflow.

## Operation
- Two-entry matrix FIFO with count 0..2. in_ready = (count != 2), decoded from registers only.
- Push occurs on in_valid && in_ready. When in_valid arrives with in_ready low, the matrix is dropped and overflow is set.
- FSM states:
  - IDLE: if count > 0, go to HDR when MAT_SER_HEADER_EN is defined, otherwise go to SEND with idx = 0.
  - HDR: present the header byte; on handshake go to SEND with idx = 0.
  - SEND: present element idx of the FIFO head. On handshake, idx increments. On the handshake of idx = 8, pop the head. If count after the pop is greater than 0, restart the next frame (HDR or SEND idx = 0) with no bubble; otherwise go to IDLE.
- m_data, m_index and m_last stay stable while m_valid && !m_ready.
- Pop and push in the same cycle: count is unchanged and the new matrix takes the freed slot. A push is not accepted on the cycle of the pop when count was 2, because in_ready was low.
- clr_overflow has priority over a simultaneous overflow set, so overflow clears.
- Arithmetic: count is 2 bits and idx is 4 bits. Neither may wrap; an assertion flags count > 2 or idx > 8.

## Timing
- Reset values: m_valid 0, m_data 0, m_index 0, m_last 0, busy 0, overflow 0, in_ready 1; count 0, FSM in IDLE.
- Latency: in_valid at edge t produces the first byte with m_valid high after edge t+1.
- Throughput: one byte per cycle when m_ready is held high; 9 cycles per matrix (10 with header).
- Reset mid-frame: outputs drop asynchronously, both buffer entries and the partial frame are discarded, and the next frame starts at idx 0.

## Configuration
- MAT_SER_HEADER_EN defined: each frame is preceded by the byte 8'hA5 with m_index 4'hF, m_last 0.
- MAT_SER_HEADER_EN undefined: no HDR state; frames are 9 bytes.

## Structure
- Package mat_ser_pkg holds:
  - ELEM_W, DIM, NUM_ELEMS
  - HEADER_BYTE = 8'hA5
  - HDR_INDEX = 4'hF
  - FSM state typedef (IDLE, HDR, SEND)
- Sub-module mat_buf_2deep: two-entry, 72-bit FIFO with push, pop, count, head output and full/empty flags. The top level contains the FSM, element mux, overflow logic and output registers.

## Test plan
- Single matrix, elements 1..9, m_ready = 1: bytes 1..9 on consecutive cycles starting at t+1; m_index 0..8; m_last only with byte 9; busy falls after it.
- Backpressure, m_ready toggling 1,0,0,1 on the same matrix: every byte is held stable while stalled; order and count are unchanged; no duplicates.
- Two in_valid pulses 1 cycle apart (matrices 1..9 and 11..19), m_ready = 1: 18 contiguous bytes with no bubble; m_last at bytes 9 and 19.
- Overflow, three pulses with m_ready = 0: in_ready falls after the second; the third sets overflow and is dropped; m_ready = 1 then streams exactly 18 bytes; clr_overflow clears the flag.
- Reset asserted after byte 4 is accepted: m_valid is 0 immediately. After release: in_ready = 1, busy = 0; the next matrix starts at m_index 0.
- With MAT_SER_HEADER_EN: the first byte is 8'hA5 with m_index F, followed by 9 elements; latency to element 0 is 2 cycles.

Source files
------------

// File: rtl/mat_result_serializer_pkg.sv
// Shared constants, FSM state type and element-select helper for the
// 3x3 matrix result serializer.
package mat_ser_pkg;

  localparam int ELEM_W    = 8;
  localparam int DIM       = 3;
  localparam int NUM_ELEMS = DIM * DIM;
  localparam int MAT_W     = NUM_ELEMS * ELEM_W;

  localparam logic [ELEM_W-1:0] HEADER_BYTE = 8'hA5;
  localparam logic [3:0]        HDR_INDEX   = 4'hF;
  localparam logic [3:0]        LAST_IDX    = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } ser_state_e;

  // Element k of a packed matrix lives at bits [k*ELEM_W +: ELEM_W].
  function automatic logic [ELEM_W-1:0] elem_sel(input logic [MAT_W-1:0] mat,
                                                 input logic [3:0]       idx);
    logic [ELEM_W-1:0] res;
    res = '0;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      if (idx == 4'(k)) res = mat[k*ELEM_W +: ELEM_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/mat_result_serializer_if.sv
// Matrix-in / byte-out handshake bundle of the result serializer.
interface mat_result_serializer_if;
  import mat_ser_pkg::*;

  logic              in_valid;
  logic [MAT_W-1:0]  in_matrix;
  logic              in_ready;
  logic              m_valid;
  logic [ELEM_W-1:0] m_data;
  logic [3:0]        m_index;
  logic              m_last;
  logic              m_ready;
  logic              busy;
  logic              overflow;
  logic              clr_overflow;

  modport master (
    output in_valid, in_matrix, m_ready, clr_overflow,
    input  in_ready, m_valid, m_data, m_index, m_last, busy, overflow
  );

  modport slave (
    input  in_valid, in_matrix, m_ready, clr_overflow,
    output in_ready, m_valid, m_data, m_index, m_last, busy, overflow
  );

endinterface

// File: rtl/mat_result_serializer_buf.sv
// Two-entry matrix FIFO; entry 0 is always the head, entry 1 the next matrix.
module mat_buf_2deep
  import mat_ser_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [MAT_W-1:0] din,
  output logic [MAT_W-1:0] head,
  output logic [MAT_W-1:0] second,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [MAT_W-1:0] ent0_r;
  logic [MAT_W-1:0] ent1_r;
  logic [1:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests so the FIFO can never over- or underflow.
  always_comb begin
    do_push_s = push && (count_r != 2'd2);
    do_pop_s  = pop && (count_r != 2'd0);
  end

  // Storage and occupancy; a pop shifts entry 1 down or refills from din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_r  <= '0;
      ent1_r  <= '0;
      count_r <= 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (count_r == 2'd0) ent0_r <= din;
          else                 ent1_r <= din;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          ent0_r  <= ent1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            ent0_r <= din;
          end else begin
            ent0_r <= ent1_r;
            ent1_r <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head   = ent0_r;
  assign second = ent1_r;
  assign count  = count_r;
  assign full   = (count_r == 2'd2);
  assign empty  = (count_r == 2'd0);

endmodule

// File: rtl/mat_result_serializer_chk.sv
// Range checks on the serializer's occupancy count and element index.
module mat_ser_checker (
  input logic       clk,
  input logic       rst,
  input logic [1:0] count,
  input logic [3:0] idx
);

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= 2'd2);
  a_idx_range:   assert property (@(posedge clk) disable iff (rst) idx <= 4'd8);

endmodule

// File: rtl/mat_result_serializer.sv
// Streams buffered 3x3 result matrices out as row-major bytes.
// Define MAT_SER_HEADER_EN to prefix each frame with an 8'hA5 header byte.
module mat_result_serializer
  import mat_ser_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  mat_result_serializer_if.slave bus
);

`ifdef MAT_SER_HEADER_EN
  localparam ser_state_e FRAME_START = HDR;
`else
  localparam ser_state_e FRAME_START = SEND;
`endif

  ser_state_e        state_r, state_nxt_s;
  logic [3:0]        idx_r, idx_nxt_s;
  logic              m_valid_r, m_valid_nxt_s;
  logic [ELEM_W-1:0] m_data_r, m_data_nxt_s;
  logic [3:0]        m_index_r, m_index_nxt_s;
  logic              m_last_r, m_last_nxt_s;
  logic              in_ready_r, busy_r, overflow_r;
  logic              overflow_nxt_s;
  logic              hs_s, push_s, pop_s;
  logic [1:0]        count_s, cnt_nxt_s;
  logic              full_s, empty_s;
  logic [MAT_W-1:0]  head_s, second_s, head_nxt_s;

  mat_buf_2deep u_buf (
    .clk    (clk),
    .rst    (rst),
    .push   (push_s),
    .pop    (pop_s),
    .din    (bus.in_matrix),
    .head   (head_s),
    .second (second_s),
    .count  (count_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  mat_ser_checker u_chk (
    .clk   (clk),
    .rst   (rst),
    .count (count_s),
    .idx   (idx_r)
  );

  // Handshakes; in_ready comes from a register so push never depends on m_ready.
  always_comb begin
    hs_s   = m_valid_r && bus.m_ready;
    push_s = bus.in_valid && in_ready_r;
  end

  // Frame sequencing; the pop of element 8 restarts at once if work remains.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_nxt_s = FRAME_START;
          idx_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR: begin
        if (hs_s) begin
          state_nxt_s = SEND;
          idx_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = HDR;
        end
      end
      SEND: begin
        if (hs_s && (idx_r == LAST_IDX)) begin
          pop_s     = 1'b1;
          idx_nxt_s = 4'd0;
          if (full_s || push_s) state_nxt_s = FRAME_START;
          else                  state_nxt_s = IDLE;
        end else if (hs_s) begin
          idx_nxt_s = idx_r + 4'd1;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = 4'd0;
      end
    endcase
  end

  // Next output byte, taken from whichever matrix will be at the head.
  always_comb begin
    cnt_nxt_s  = count_s + {1'b0, push_s} - {1'b0, pop_s};
    head_nxt_s = pop_s ? (full_s ? second_s : bus.in_matrix) : head_s;
    case (state_nxt_s)
      HDR: begin
        m_valid_nxt_s = 1'b1;
        m_data_nxt_s  = HEADER_BYTE;
        m_index_nxt_s = HDR_INDEX;
        m_last_nxt_s  = 1'b0;
      end
      SEND: begin
        m_valid_nxt_s = 1'b1;
        m_data_nxt_s  = elem_sel(head_nxt_s, idx_nxt_s);
        m_index_nxt_s = idx_nxt_s;
        m_last_nxt_s  = (idx_nxt_s == LAST_IDX);
      end
      default: begin
        m_valid_nxt_s = 1'b0;
        m_data_nxt_s  = '0;
        m_index_nxt_s = 4'd0;
        m_last_nxt_s  = 1'b0;
      end
    endcase
    if (bus.clr_overflow)                  overflow_nxt_s = 1'b0;
    else if (bus.in_valid && !in_ready_r)  overflow_nxt_s = 1'b1;
    else                                   overflow_nxt_s = overflow_r;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= 4'd0;
      m_valid_r  <= 1'b0;
      m_data_r   <= '0;
      m_index_r  <= 4'd0;
      m_last_r   <= 1'b0;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      m_valid_r  <= m_valid_nxt_s;
      m_data_r   <= m_data_nxt_s;
      m_index_r  <= m_index_nxt_s;
      m_last_r   <= m_last_nxt_s;
      in_ready_r <= (cnt_nxt_s != 2'd2);
      busy_r     <= (cnt_nxt_s != 2'd0) || (state_nxt_s != IDLE);
      overflow_r <= overflow_nxt_s;
    end
  end

  assign bus.m_valid  = m_valid_r;
  assign bus.m_data   = m_data_r;
  assign bus.m_index  = m_index_r;
  assign bus.m_last   = m_last_r;
  assign bus.in_ready = in_ready_r;
  assign bus.busy     = busy_r;
  assign bus.overflow = overflow_r;

endmodule
